uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one uart_tx instance between NUM_REQ byte-stream requesters. It grants the transmitter to one requester per message, launches each byte with a single-cycle tx_start, and tracks tx_busy to detect frame completion. A message is held until the requester's last byte or until a MAX_BURST byte limit, so no requester can starve the others. The block sits between the system-side message sources and uart_tx; baud timing stays entirely inside uart_tx.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the uart_tx arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 arb_busy;
  logic                 err_timeout;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ack, tx_start, tx_data, grant, arb_busy, err_timeout
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ack, tx_start, tx_data, grant, arb_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte-stream requesters.
// A grant lasts one message or MAX_BURST bytes, whichever ends first.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ARB, WAIT_BUSY, WAIT_DONE, NEXT} state_t;

  state_t             state, state_n;
  logic [IW-1:0]      ptr, ptr_n, owner, owner_n, win, lidx, jj;
  logic               found, launch, rel;
  logic [3:0]         burst, burst_n;
  logic               lock, lock_n;
  logic [7:0]         tcnt, tcnt_n;
  logic [7:0]         data_q, data_n;
  logic               start_q, start_n, err_q, err_n, abusy_q, abusy_n;
  logic [NUM_REQ-1:0] ack_q, ack_n, grant_q, grant_n;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    jj    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      jj = (int'(ptr) + k >= NUM_REQ) ? IW'(int'(ptr) + k - NUM_REQ) : IW'(int'(ptr) + k);
      if (!found && bus.req_valid[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    burst_n = burst;
    lock_n  = lock;
    tcnt_n  = tcnt;
    data_n  = data_q;
    start_n = 1'b0;
    ack_n   = '0;
    grant_n = grant_q;
    err_n   = 1'b0;
    launch  = 1'b0;
    rel     = 1'b0;
    lidx    = owner;

    unique case (state)
      ARB: begin
        if (found) begin
          launch  = 1'b1;
          lidx    = win;
          burst_n = 4'd1;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_n = WAIT_DONE;
          tcnt_n  = '0;
        end else if (tcnt == 8'(BUSY_TIMEOUT - 1)) begin
          // Byte already acked to the requester; it is dropped, not retried.
          err_n  = 1'b1;
          rel    = 1'b1;
          tcnt_n = '0;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (lock && burst < 4'(MAX_BURST)) state_n = NEXT;
          else                               rel     = 1'b1;
        end
      end
      NEXT: begin
        if (bus.req_valid[owner]) begin
          launch  = 1'b1;
          burst_n = (burst < 4'(MAX_BURST)) ? burst + 4'd1 : burst;
        end else begin
          rel = 1'b1;
        end
      end
      default: state_n = ARB;
    endcase

    if (launch) begin
      owner_n      = lidx;
      grant_n      = NUM_REQ'(1) << lidx;
      data_n       = bus.req_data[{lidx, 3'b000} +: 8];
      start_n      = 1'b1;
      ack_n[lidx]  = 1'b1;
      lock_n       = !bus.req_last[lidx];
      tcnt_n       = '0;
      state_n      = WAIT_BUSY;
    end

    if (rel) begin
      grant_n = '0;
      ptr_n   = inc_idx(owner);
      state_n = ARB;
    end

    abusy_n = (state_n != ARB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      ptr     <= '0;
      owner   <= '0;
      burst   <= '0;
      lock    <= 1'b0;
      tcnt    <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      abusy_q <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      burst   <= burst_n;
      lock    <= lock_n;
      tcnt    <= tcnt_n;
      data_q  <= data_n;
      start_q <= start_n;
      ack_q   <= ack_n;
      grant_q <= grant_n;
      err_q   <= err_n;
      abusy_q <= abusy_n;
    end
  end

  assign bus.tx_start    = start_q;
  assign bus.tx_data     = data_q;
  assign bus.req_ack     = ack_q;
  assign bus.grant       = grant_q;
  assign bus.err_timeout = err_q;
  assign bus.arb_busy    = abusy_q;
endmodule
